// File: rtl/invaders_video_scan.sv
// invaders_video_scan: raster timing generator and 1bpp bitmap reader for the
// video RAM. One byte is fetched per 8 pixels from the bitmap at VRAM_BASE
// and shifted out LSB first. Mid-screen and end-of-screen interrupt pulses
// are raised for the CPU.
//
// Ports:
//   Clock     sole clock
//   Reset_n   synchronous active-low reset
//   Pix_Ce    pixel clock enable (at most one pulse per 2 Clocks)
//   Ram_Data  RAM read data, valid 1 Clock after Ram_Addr
//   Ram_Addr  RAM read address (offset within the 8 KB RAM)
//   Ram_Rd    one-Clock strobe marking a new fetch address
//   Pixel     serial pixel
//   HBlank / VBlank    blanking flags
//   HSync_n / VSync_n  active-low syncs
//   Int_Mid / Int_End  one-Clock interrupt requests (RST 1 / RST 2)
//
// Optional macro INVADERS_FLIP_EN adds input Flip (sampled at each line start)
// which inverts the fetch address and serialises bytes MSB first.
module invaders_video_scan #(
  parameter int unsigned H_TOTAL   = 320,
  parameter int unsigned V_TOTAL   = 262,
  parameter int unsigned H_ACTIVE  = 256,
  parameter int unsigned V_ACTIVE  = 224,
  parameter int unsigned HS_START  = 272,
  parameter int unsigned HS_END    = 304,
  parameter int unsigned VS_START  = 236,
  parameter int unsigned VS_END    = 240,
  parameter int unsigned MID_LINE  = 96,
  parameter logic [12:0] VRAM_BASE = 13'h0400
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Pix_Ce,
`ifdef INVADERS_FLIP_EN
  input  logic        Flip,
`endif
  input  logic [7:0]  Ram_Data,
  output logic [12:0] Ram_Addr,
  output logic        Ram_Rd,
  output logic        Pixel,
  output logic        HBlank,
  output logic        VBlank,
  output logic        HSync_n,
  output logic        VSync_n,
  output logic        Int_Mid,
  output logic        Int_End
);

  localparam logic [8:0] H_TOT9 = 9'(H_TOTAL);
  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
  localparam logic [8:0] H_ACT  = 9'(H_ACTIVE);
  localparam logic [8:0] V_ACT  = 9'(V_ACTIVE);
  localparam logic [8:0] HS_S   = 9'(HS_START);
  localparam logic [8:0] HS_E   = 9'(HS_END);
  localparam logic [8:0] VS_S   = 9'(VS_START);
  localparam logic [8:0] VS_E   = 9'(VS_END);
  localparam logic [8:0] MID    = 9'(MID_LINE);

  logic [8:0]  h_q, h_d, v_q, v_d;
  logic [12:0] ram_addr_q, ram_addr_d;
  logic        ram_rd_q, ram_rd_d;
  logic [7:0]  pix_byte_q, pix_byte_d;
  logic        pixel_q, pixel_d;
  logic        hblank_q, hblank_d;
  logic        vblank_q, vblank_d;
  logic        hsync_n_q, hsync_n_d;
  logic        vsync_n_q, vsync_n_d;
  logic        int_mid_q, int_mid_d;
  logic        int_end_q, int_end_d;

  logic        h_wrap, v_wrap;
  logic [8:0]  h_nxt, v_nxt;
  logic        f_wrap;
  logic [5:0]  f_c;
  logic [8:0]  f_v;
  logic [7:0]  f_row;
  logic [4:0]  f_col;
  logic [12:0] f_addr;
  logic        fetch_flip, ser_flip;
  logic [2:0]  k;

`ifdef INVADERS_FLIP_EN
  logic flip_q, flip_d;

  always_comb begin
    flip_d = flip_q;
    if (Pix_Ce && h_wrap) flip_d = Flip;
    // Column-0 fetch happens 2 pixels before the line start that samples
    // Flip, so it looks at the live input instead of the latched value.
    fetch_flip = f_wrap ? Flip : flip_q;
    ser_flip   = flip_d;
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) flip_q <= Flip;
    else          flip_q <= flip_d;
  end
`else
  always_comb begin
    fetch_flip = 1'b0;
    ser_flip   = 1'b0;
  end
`endif

  // Next raster position
  always_comb begin
    h_wrap = (h_q == H_LAST);
    v_wrap = (v_q == V_LAST);
    h_nxt  = h_wrap ? '0 : h_q + 9'd1;
    v_nxt  = h_wrap ? (v_wrap ? '0 : v_q + 9'd1) : v_q;
  end

  // Fetch target: column starting 2 pixels ahead, possibly on the next line
  always_comb begin
    f_wrap = (h_q >= H_LAST - 9'd1);
    f_c    = f_wrap ? 6'((h_q + 9'd2 - H_TOT9) >> 3) : 6'((h_q + 9'd2) >> 3);
    f_v    = f_wrap ? (v_wrap ? '0 : v_q + 9'd1) : v_q;
    f_row  = fetch_flip ? 8'(V_ACT - 9'd1 - f_v) : f_v[7:0];
    f_col  = fetch_flip ? ~f_c[4:0] : f_c[4:0];
    f_addr = VRAM_BASE + {f_row, 5'b0} + {8'b0, f_col};
  end

  always_comb begin
    h_d        = h_q;
    v_d        = v_q;
    ram_addr_d = ram_addr_q;
    ram_rd_d   = 1'b0;
    pix_byte_d = pix_byte_q;
    pixel_d    = pixel_q;
    hblank_d   = hblank_q;
    vblank_d   = vblank_q;
    hsync_n_d  = hsync_n_q;
    vsync_n_d  = vsync_n_q;
    int_mid_d  = 1'b0;
    int_end_d  = 1'b0;
    k          = h_nxt[2:0];

    if (Pix_Ce) begin
      h_d = h_nxt;
      v_d = v_nxt;

      if (h_q[2:0] == 3'd6 && f_c < 6'd32 && f_v < V_ACT) begin
        ram_addr_d = f_addr;
        ram_rd_d   = 1'b1;
      end

      if (h_q[2:0] == 3'd7)
        pix_byte_d = (h_nxt[8:3] < 6'd32 && v_nxt < V_ACT) ? Ram_Data : '0;

      hblank_d  = (h_nxt >= H_ACT);
      vblank_d  = (v_nxt >= V_ACT);
      hsync_n_d = !(h_nxt >= HS_S && h_nxt < HS_E);
      vsync_n_d = !(v_nxt >= VS_S && v_nxt < VS_E);
      pixel_d   = (ser_flip ? pix_byte_d[~k] : pix_byte_d[k])
                  && !(h_nxt >= H_ACT) && !(v_nxt >= V_ACT);
      int_mid_d = h_wrap && (v_nxt == MID);
      int_end_d = h_wrap && (v_nxt == V_ACT);
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      h_q        <= '0;
      v_q        <= '0;
      ram_addr_q <= VRAM_BASE;
      ram_rd_q   <= 1'b0;
      pix_byte_q <= '0;
      pixel_q    <= 1'b0;
      hblank_q   <= 1'b0;
      vblank_q   <= 1'b0;
      hsync_n_q  <= 1'b1;
      vsync_n_q  <= 1'b1;
      int_mid_q  <= 1'b0;
      int_end_q  <= 1'b0;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      ram_addr_q <= ram_addr_d;
      ram_rd_q   <= ram_rd_d;
      pix_byte_q <= pix_byte_d;
      pixel_q    <= pixel_d;
      hblank_q   <= hblank_d;
      vblank_q   <= vblank_d;
      hsync_n_q  <= hsync_n_d;
      vsync_n_q  <= vsync_n_d;
      int_mid_q  <= int_mid_d;
      int_end_q  <= int_end_d;
    end
  end

  assign Ram_Addr = ram_addr_q;
  assign Ram_Rd   = ram_rd_q;
  assign Pixel    = pixel_q;
  assign HBlank   = hblank_q;
  assign VBlank   = vblank_q;
  assign HSync_n  = hsync_n_q;
  assign VSync_n  = vsync_n_q;
  assign Int_Mid  = int_mid_q;
  assign Int_End  = int_end_q;

endmodule

// File: tb/tb_invaders_video_scan.sv
// Directed bench: a default-parameter instance for line-level behaviour and
// a reduced-frame instance (272x36, 32 visible lines, base 0x1C00) for
// frame-level behaviour, both driven from the same clock, reset and Pix_Ce.
module tb_invaders_video_scan;

  logic        Clock;
  logic        Reset_n;
  logic        Pix_Ce;
  logic        b_flip, s_flip;
  logic [7:0]  b_ram_data, s_ram_data;
  logic [12:0] b_ram_addr, s_ram_addr;
  logic        b_ram_rd, b_pixel, b_hblank, b_vblank, b_hsync_n, b_vsync_n, b_int_mid, b_int_end;
  logic        s_ram_rd, s_pixel, s_hblank, s_vblank, s_hsync_n, s_vsync_n, s_int_mid, s_int_end;

  int n_tests = 0;
  int n_fail  = 0;

  int bh, bv, sh, sv, sf, step_no;

  invaders_video_scan u_dut (
    .Clock(Clock), .Reset_n(Reset_n), .Pix_Ce(Pix_Ce),
`ifdef INVADERS_FLIP_EN
    .Flip(b_flip),
`endif
    .Ram_Data(b_ram_data), .Ram_Addr(b_ram_addr), .Ram_Rd(b_ram_rd),
    .Pixel(b_pixel), .HBlank(b_hblank), .VBlank(b_vblank),
    .HSync_n(b_hsync_n), .VSync_n(b_vsync_n),
    .Int_Mid(b_int_mid), .Int_End(b_int_end)
  );

  invaders_video_scan #(
    .H_TOTAL(272), .V_TOTAL(36), .H_ACTIVE(256), .V_ACTIVE(32),
    .HS_START(260), .HS_END(268), .VS_START(33), .VS_END(35),
    .MID_LINE(12), .VRAM_BASE(13'h1C00)
  ) u_dut_s (
    .Clock(Clock), .Reset_n(Reset_n), .Pix_Ce(Pix_Ce),
`ifdef INVADERS_FLIP_EN
    .Flip(s_flip),
`endif
    .Ram_Data(s_ram_data), .Ram_Addr(s_ram_addr), .Ram_Rd(s_ram_rd),
    .Pixel(s_pixel), .HBlank(s_hblank), .VBlank(s_vblank),
    .HSync_n(s_hsync_n), .VSync_n(s_vsync_n),
    .Int_Mid(s_int_mid), .Int_End(s_int_end)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [7:0] mem(input logic [12:0] a);
    case (a)
      13'h0400, 13'h1C00: mem = 8'h81;
      13'h0421:           mem = 8'h35;
      13'h1FFF:           mem = 8'h80;
      default:            mem = 8'h00;
    endcase
  endfunction

  always @(posedge Clock) begin
    b_ram_data <= mem(b_ram_addr);
    s_ram_data <= mem(s_ram_addr);
  end

  // Interrupt pulse counters for the reduced instance
  int mid_pulses = 0, end_pulses = 0, int_wide = 0;
  logic mid_prev = 1'b0, end_prev = 1'b0;
  always @(negedge Clock) begin
    if (s_int_mid === 1'b1) mid_pulses++;
    if (s_int_end === 1'b1) end_pulses++;
    if ((s_int_mid === 1'b1 && mid_prev) || (s_int_end === 1'b1 && end_prev)) int_wide++;
    mid_prev = (s_int_mid === 1'b1);
    end_prev = (s_int_end === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    bh = 0; bv = 0; sh = 0; sv = 0; sf = 0; step_no = 0;
  endtask

  task automatic advance();
    bh++;
    if (bh == 320) begin bh = 0; bv++; if (bv == 262) bv = 0; end
    sh++;
    if (sh == 272) begin sh = 0; sv++; if (sv == 36) begin sv = 0; sf++; end end
    step_no++;
  endtask

  task automatic ce_edge();
    Pix_Ce = 1'b1;
    @(posedge Clock); #1;
    Pix_Ce = 1'b0;
    advance();
  endtask

  task automatic idle();
    @(posedge Clock); #1;
  endtask

  initial begin
    logic [7:0] pat;
    logic [31:0] e;
    int b_rd_cnt, b_hs_low, s_vs_low, s_rd_blank, rd_idle_hi;
    int first_mid, first_end, mid_base, end_base, wide_base;

    Reset_n = 1'b0; Pix_Ce = 1'b0; b_flip = 1'b0; s_flip = 1'b0;
    repeat (3) @(posedge Clock);
    #1 Reset_n = 1'b1;
    reset_model();
    repeat (300) begin ce_edge(); idle(); end
    chk("pre_rst_hblank", 32'(b_hblank), 1);
    chk("pre_rst_hsync", 32'(b_hsync_n), 0);

    // Mid-line reset with Pix_Ce still pulsing
    Reset_n = 1'b0;
    Pix_Ce = 1'b1; @(posedge Clock); #1;
    Pix_Ce = 1'b0; @(posedge Clock); #1;
    Pix_Ce = 1'b1; @(posedge Clock); #1;
    Pix_Ce = 1'b0;
    chk("rst_addr", 32'(b_ram_addr), 32'h0400);
    chk("rst_addr_s", 32'(s_ram_addr), 32'h1C00);
    chk("rst_rd", 32'(b_ram_rd), 0);
    chk("rst_pixel", 32'(b_pixel), 0);
    chk("rst_hblank", 32'(b_hblank), 0);
    chk("rst_vblank", 32'(b_vblank), 0);
    chk("rst_hsync", 32'(b_hsync_n), 1);
    chk("rst_vsync", 32'(b_vsync_n), 1);
    chk("rst_int_mid", 32'(b_int_mid), 0);
    chk("rst_int_end", 32'(b_int_end), 0);
    Reset_n = 1'b1;
    reset_model();

    b_rd_cnt = 0; b_hs_low = 0; s_vs_low = 0; s_rd_blank = 0; rd_idle_hi = 0;
    first_mid = -1; first_end = -1;
    mid_base = mid_pulses; end_base = end_pulses; wide_base = int_wide;

    for (int i = 0; i < 2 * 9792; i++) begin
      ce_edge();
      if (b_ram_rd) b_rd_cnt++;
      if (!b_hsync_n) b_hs_low++;
      if (!s_vsync_n) s_vs_low++;
      if (s_ram_rd && sv >= 32 && !(sh == 271 && sv == 35)) s_rd_blank++;
      if (s_int_mid && first_mid < 0) first_mid = step_no;
      if (s_int_end && first_end < 0) first_end = step_no;

      if (bv == 0 && bh == 7) begin
        chk("b_rd_col1", 32'(b_ram_rd), 1);
        chk("b_addr_col1", 32'(b_ram_addr), 32'h0401);
      end
      if (bv == 0 && bh == 319) begin
        chk("b_rd_l1c0", 32'(b_ram_rd), 1);
        chk("b_addr_l1c0", 32'(b_ram_addr), 32'h0420);
      end
      if (bv == 1) begin
        case (bh)
          255: chk("b_hblank_255", 32'(b_hblank), 0);
          256: chk("b_hblank_256", 32'(b_hblank), 1);
          271: chk("b_hsync_271", 32'(b_hsync_n), 1);
          272: chk("b_hsync_272", 32'(b_hsync_n), 0);
          303: chk("b_hsync_303", 32'(b_hsync_n), 0);
          304: chk("b_hsync_304", 32'(b_hsync_n), 1);
          default: ;
        endcase
        if (bh >= 7 && bh <= 16) begin
          pat = 8'h35;
          e = (bh >= 8 && bh <= 15) ? 32'(pat[bh-8]) : 32'd0;
          chk("b_pix_l1", 32'(b_pixel), e);
        end
      end

      if (sf == 0 && sv == 0 && sh >= 1 && sh <= 8)
        chk("s_pix_f0", 32'(s_pixel), 0);
      if (sf == 1 && sv == 0 && sh <= 8) begin
        pat = 8'h81;
        e = (sh < 8) ? 32'(pat[sh]) : 32'd0;
        chk("s_pix_f1", 32'(s_pixel), e);
      end
      if (sf == 0) begin
        if (sv == 31 && sh == 247) begin
          chk("s_rd_last", 32'(s_ram_rd), 1);
          chk("s_addr_last", 32'(s_ram_addr), 32'h1FFF);
        end
        if (sv == 35 && sh == 271) begin
          chk("s_rd_l0c0", 32'(s_ram_rd), 1);
          chk("s_addr_l0c0", 32'(s_ram_addr), 32'h1C00);
        end
        if (sv == 31 && sh == 271) chk("s_vblank_31", 32'(s_vblank), 0);
        if (sv == 32 && sh == 0) begin
          chk("s_vblank_32", 32'(s_vblank), 1);
          chk("s_int_end_at", 32'(s_int_end), 1);
        end
        if (sv == 12 && sh == 0) chk("s_int_mid_at", 32'(s_int_mid), 1);
        if (sv == 32 && sh == 271) chk("s_vsync_32", 32'(s_vsync_n), 1);
        if (sv == 33 && sh == 0)   chk("s_vsync_33", 32'(s_vsync_n), 0);
        if (sv == 34 && sh == 271) chk("s_vsync_34", 32'(s_vsync_n), 0);
        if (sv == 35 && sh == 0)   chk("s_vsync_35", 32'(s_vsync_n), 1);
      end

      idle();
      if (b_ram_rd || s_ram_rd) rd_idle_hi++;
      if (bv == 0 && bh == 7) chk("b_addr_hold", 32'(b_ram_addr), 32'h0401);
    end

    chk("b_rd_count", b_rd_cnt, 1960);
    chk("b_hsync_low", b_hs_low, 1952);
    chk("s_vsync_low", s_vs_low, 1088);
    chk("s_rd_in_vblank", s_rd_blank, 0);
    chk("rd_without_ce", rd_idle_hi, 0);
    chk("s_first_mid_step", first_mid, 3264);
    chk("s_first_end_step", first_end, 8704);
    chk("s_mid_pulses", mid_pulses - mid_base, 2);
    chk("s_end_pulses", end_pulses - end_base, 2);
    chk("s_int_wide", int_wide - wide_base, 0);

`ifdef INVADERS_FLIP_EN
    s_flip = 1'b1;
    Reset_n = 1'b0;
    repeat (3) @(posedge Clock);
    #1 Reset_n = 1'b1;
    reset_model();
    repeat (9800) begin
      ce_edge();
      if (sf == 0 && sv == 0 && sh == 7) begin
        chk("flip_rd_col1", 32'(s_ram_rd), 1);
        chk("flip_addr_col1", 32'(s_ram_addr), 32'h1FFE);
      end
      if (sf == 0 && sv == 35 && sh == 271) begin
        chk("flip_rd_l0c0", 32'(s_ram_rd), 1);
        chk("flip_addr_l0c0", 32'(s_ram_addr), 32'h1FFF);
      end
      if (sf == 1 && sv == 0 && sh <= 7)
        chk("flip_pix", 32'(s_pixel), (sh == 0) ? 32'd1 : 32'd0);
      idle();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
